ddfs_octant_unfold: RTL and testbench
=====================================

Name: ddfs_octant_unfold

Overview:
- Back end of the DDFS phase-to-amplitude path; the inverse of the phase-truncation stage.
- Consumes the octant code phi_r and fine-rotation bits phi_rot produced by the truncation stage, plus the coarse first-octant sin/cos values read from the LUT at phi_lut.
- Applies a first-order fine-angle correction, then unfolds the first-octant result to full-circle signed sine and cosine.
- 3-stage pipeline with valid tracking and a global clock enable.

Parameters:
- N, 17, truncated phase width (matches truncation stage)
- L, 6, LUT address width (matches truncation stage)
- R, N-3-L (=8), phi_rot width; derived, do not override
- W, 16, unsigned LUT amplitude width (Q0.W)
- K_DELTA, 804, coarse LUT step in radians, Q0.16 (round(2^16*(pi/4)/2^L))

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  pipeline enable; low freezes every stage
- in_valid  in  1  input sample valid
- phi_r  in  3  octant code 0..7
- phi_rot  in  R  fine angle, fraction of one LUT step (unsigned)
- lut_sin  in  W  sin(theta_coarse), first octant, unsigned
- lut_cos  in  W  cos(theta_coarse), first octant, unsigned
- out_valid  out  1  output sample valid
- out_sin  out  W+1  signed two's-complement sine
- out_cos  out  W+1  signed two's-complement cosine

Behaviour:
- Reset (async, rst=1): all pipeline registers, valid bits and outputs go to 0 immediately. Reset mid-stream discards in-flight samples; the first valid output after release comes from the first sample accepted after release.
- en=0: no register changes, including valid bits. en=1: every stage advances. in_valid is sampled only when en=1.
- Latency: exactly 3 enabled clock edges from input capture to out_valid/out_sin/out_cos. Throughput is 1 sample per enabled cycle. Bubbles (in_valid=0) propagate as out_valid=0; data registers still load but their values are don't-care.
- Stage 1: register phi_r, phi_rot, lut_sin, lut_cos and in_valid.
- Stage 2, fine correction, all products unsigned and full width:
  - cs = (lut_cos*phi_rot*K_DELTA) >> (R+16)
  - cc = (lut_sin*phi_rot*K_DELTA) >> (R+16)
  - s = lut_sin + cs, saturated to 2^W-1
  - c = lut_cos - cc, clamped at 0
  - Truncation is floor. phi_r and valid are delayed alongside.
- Stage 3, octant unfold; s and c are zero-extended to W+1 bits before negation:
  - 0: sin=+s, cos=+c
  - 1: sin=+c, cos=+s
  - 2: sin=+c, cos=-s
  - 3: sin=+s, cos=-c
  - 4: sin=-s, cos=-c
  - 5: sin=-c, cos=-s
  - 6: sin=-c, cos=+s
  - 7: sin=-s, cos=+c
- Negation never overflows, since |value| <= 2^W-1. Negative zero does not exist; -0 = 0.
- Upstream already mirrors phi_lut/phi_rot in odd octants; this block does not mirror them again.
- Outputs hold their last value while en=0 or after a bubble. out_valid alone qualifies them.

Test Plan:
- Reset/latency: assert rst mid-stream with 3 samples in flight -> out_valid=0 and outputs 0 immediately. After release, apply 1 sample with en=1 -> out_valid first high on the 3rd edge, not earlier.
- Octant 0/4 axis: phi_rot=0, lut_sin=0, lut_cos=65535. phi_r=0 -> out_sin=0, out_cos=65535. phi_r=4 -> out_sin=0, out_cos=-65535.
- Fine correction: phi_r=0, lut_sin=1000, lut_cos=40000, phi_rot=128 -> out_sin=1245, out_cos=39994.
- Saturation: phi_r=0, lut_sin=65500, lut_cos=65535, phi_rot=255 -> out_sin=65535 (saturated), out_cos=64735.
- All octants: lut_sin=1000, lut_cos=40000, phi_rot=0, phi_r=0..7 back-to-back -> one result per cycle, matching the mapping table (for example octant 5 -> out_sin=-40000, out_cos=-1000).
- Enable stall: stream 5 samples, drop en for 4 cycles mid-stream -> no output or valid change while stalled; no sample is lost or duplicated, and order is preserved.

Source files
------------

// File: rtl/ddfs_octant_unfold.sv
`default_nettype none
// ============================================================================
//  Module   : ddfs_octant_unfold
//  Purpose  : DDFS back end. Applies a first-order fine-angle correction to
//             the coarse first-octant sin/cos LUT values, then unfolds the
//             result to full-circle signed sine and cosine.
//             Three-stage pipeline with valid tracking and a global enable.
//  Revision : 1.0  initial release
// ============================================================================
module ddfs_octant_unfold #(
  parameter  int N       = 17,
  parameter  int L       = 6,
  parameter  int W       = 16,
  parameter  int K_DELTA = 804,
  localparam int R       = N - 3 - L
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           in_valid,
  input  logic [2:0]     phi_r,
  input  logic [R-1:0]   phi_rot,
  input  logic [W-1:0]   lut_sin,
  input  logic [W-1:0]   lut_cos,
  output logic           out_valid,
  output logic [W:0]     out_sin,
  output logic [W:0]     out_cos
);

  // Product width: amplitude (W) x fine angle (R) x Q0.16 step constant.
  localparam int PW = W + R + 16;
  localparam int SH = R + 16;

  // --------------------------------------------------------------------------
  // Stage 1 registers
  // --------------------------------------------------------------------------
  logic           s1_valid_q;
  logic [2:0]     s1_phi_r_q;
  logic [R-1:0]   s1_rot_q;
  logic [W-1:0]   s1_sin_q;
  logic [W-1:0]   s1_cos_q;

  // Stage 1: capture the raw inputs; valid is sampled only when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_phi_r_q <= '0;
      s1_rot_q   <= '0;
      s1_sin_q   <= '0;
      s1_cos_q   <= '0;
    end else if (en) begin
      s1_valid_q <= in_valid;
      s1_phi_r_q <= phi_r;
      s1_rot_q   <= phi_rot;
      s1_sin_q   <= lut_sin;
      s1_cos_q   <= lut_cos;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: fine-angle correction
  //   sin(a+d) ~ sin(a) + d*cos(a),  cos(a+d) ~ cos(a) - d*sin(a)
  //   with d = phi_rot/2^R * K_DELTA/2^16 radians.
  // --------------------------------------------------------------------------
  logic [PW-1:0]  w_prod_cs;
  logic [PW-1:0]  w_prod_cc;
  logic [W-1:0]   w_cs;
  logic [W-1:0]   w_cc;
  logic [W:0]     w_s_sum;

  assign w_prod_cs = PW'(s1_cos_q) * PW'(s1_rot_q) * PW'(K_DELTA);
  assign w_prod_cc = PW'(s1_sin_q) * PW'(s1_rot_q) * PW'(K_DELTA);
  // The correction is always below one LUT step, so it fits in W bits.
  assign w_cs      = W'(w_prod_cs >> SH);
  assign w_cc      = W'(w_prod_cc >> SH);
  assign w_s_sum   = {1'b0, s1_sin_q} + {1'b0, w_cs};

  logic           s2_valid_q;
  logic [2:0]     s2_phi_r_q;
  logic [W-1:0]   s2_s_q;
  logic [W-1:0]   s2_c_q;
  logic [W-1:0]   s2_s_d;
  logic [W-1:0]   s2_c_d;

  // Saturate the corrected sine at full scale and clamp the cosine at zero.
  always_comb begin
    s2_s_d = w_s_sum[W] ? {W{1'b1}} : w_s_sum[W-1:0];
    s2_c_d = (w_cc > s1_cos_q) ? '0 : (s1_cos_q - w_cc);
  end

  // Stage 2 register: corrected magnitudes with octant and valid delayed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_phi_r_q <= '0;
      s2_s_q     <= '0;
      s2_c_q     <= '0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      s2_phi_r_q <= s1_phi_r_q;
      s2_s_q     <= s2_s_d;
      s2_c_q     <= s2_c_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: octant unfold to signed full-circle values
  // --------------------------------------------------------------------------
  logic [W:0]     w_pos_s;
  logic [W:0]     w_pos_c;
  logic [W:0]     w_neg_s;
  logic [W:0]     w_neg_c;
  logic [W:0]     out_sin_d;
  logic [W:0]     out_cos_d;

  // Magnitudes are at most 2^W-1, so the W+1 bit negation cannot overflow
  // and -0 naturally comes out as 0.
  assign w_pos_s = {1'b0, s2_s_q};
  assign w_pos_c = {1'b0, s2_c_q};
  assign w_neg_s = -w_pos_s;
  assign w_neg_c = -w_pos_c;

  // Select swap/negation of the first-octant pair from the octant code.
  always_comb begin
    out_sin_d = w_pos_s;
    out_cos_d = w_pos_c;
    case (s2_phi_r_q)
      3'd0: begin out_sin_d = w_pos_s; out_cos_d = w_pos_c; end
      3'd1: begin out_sin_d = w_pos_c; out_cos_d = w_pos_s; end
      3'd2: begin out_sin_d = w_pos_c; out_cos_d = w_neg_s; end
      3'd3: begin out_sin_d = w_pos_s; out_cos_d = w_neg_c; end
      3'd4: begin out_sin_d = w_neg_s; out_cos_d = w_neg_c; end
      3'd5: begin out_sin_d = w_neg_c; out_cos_d = w_neg_s; end
      3'd6: begin out_sin_d = w_neg_c; out_cos_d = w_pos_s; end
      3'd7: begin out_sin_d = w_neg_s; out_cos_d = w_pos_c; end
      default: begin out_sin_d = w_pos_s; out_cos_d = w_pos_c; end
    endcase
  end

  logic           out_valid_q;
  logic [W:0]     out_sin_q;
  logic [W:0]     out_cos_q;

  // Output register: data only updates for valid samples so bubbles hold it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sin_q   <= '0;
      out_cos_q   <= '0;
    end else if (en) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_sin_q <= out_sin_d;
        out_cos_q <= out_cos_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sin   = out_sin_q;
  assign out_cos   = out_cos_q;

endmodule
`default_nettype wire

// File: tb/tb_ddfs_octant_unfold.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddfs_octant_unfold
//  Purpose  : Self-checking bench for ddfs_octant_unfold: directed corner
//             cases plus randomized traffic against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ddfs_octant_unfold;

  localparam int  W  = 16;
  localparam int  R  = 8;
  localparam longint K = 804;

  logic          clk;
  logic          rst;
  logic          en;
  logic          in_valid;
  logic [2:0]    phi_r;
  logic [R-1:0]  phi_rot;
  logic [W-1:0]  lut_sin;
  logic [W-1:0]  lut_cos;
  logic          out_valid;
  logic [W:0]    out_sin;
  logic [W:0]    out_cos;

  ddfs_octant_unfold dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .phi_r     (phi_r),
    .phi_rot   (phi_rot),
    .lut_sin   (lut_sin),
    .lut_cos   (lut_cos),
    .out_valid (out_valid),
    .out_sin   (out_sin),
    .out_cos   (out_cos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] s;
    logic [W:0] c;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  int   ecnt    = 0;
  int   n_check = 0;
  int   n_err   = 0;

  // Reference: small-angle rotation of the first-octant pair, then the
  // full-circle value from the octant's angle-addition identity.
  function automatic void model(input int pr, input longint rot, input longint sn,
                                input longint cs, output logic [W:0] os,
                                output logic [W:0] oc);
    longint s, c, vs, vc;
    s = sn + (cs * rot * K) / (longint'(1) << 24);
    c = cs - (sn * rot * K) / (longint'(1) << 24);
    if (s > 65535) s = 65535;
    if (c < 0) c = 0;
    case (pr)
      0: begin vs =  s; vc =  c; end
      1: begin vs =  c; vc =  s; end
      2: begin vs =  c; vc = -s; end
      3: begin vs =  s; vc = -c; end
      4: begin vs = -s; vc = -c; end
      5: begin vs = -c; vc = -s; end
      6: begin vs = -c; vc =  s; end
      default: begin vs = -s; vc = c; end
    endcase
    os = 17'(vs);
    oc = 17'(vc);
  endfunction

  // Drive one cycle of stimulus, advance one edge, record expected result.
  task automatic step(input bit e, input bit v, input logic [2:0] pr,
                      input logic [R-1:0] rot, input logic [W-1:0] sn,
                      input logic [W-1:0] cs);
    exp_t x;
    en = e; in_valid = v; phi_r = pr; phi_rot = rot; lut_sin = sn; lut_cos = cs;
    @(posedge clk);
    if (e && !rst) begin
      ecnt++;
      if (v) begin
        model(int'(pr), longint'(rot), longint'(sn), longint'(cs), x.s, x.c);
        x.idx = ecnt;
        exp_q.push_back(x);
      end
    end
    #1;
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd0, '0, '0, '0);
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; in_valid = 1'b0;
    phi_r = '0; phi_rot = '0; lut_sin = '0; lut_cos = '0;
    repeat (2) @(posedge clk);
    #1;
    n_check++;
    if (out_valid !== 1'b0 || out_sin !== '0 || out_cos !== '0) begin
      n_err++;
      $display("FAIL reset_init: valid=%b sin=%h cos=%h, expected 0 0 0", out_valid, out_sin, out_cos);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'(i), 8'd17, 16'd5000, 16'd30000);
    n_check++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_valid: valid=%b, expected 1", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_check++;
    if (out_valid !== 1'b0 || out_sin !== '0 || out_cos !== '0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b sin=%h cos=%h, expected 0 0 0", out_valid, out_sin, out_cos);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    step(1'b1, 1'b1, 3'd3, 8'd0, 16'd1000, 16'd40000);
    n_check++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_edge1: valid=%b, expected 0", out_valid);
    end
    step(1'b1, 1'b0, 3'd0, '0, '0, '0);
    n_check++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_edge2: valid=%b, expected 0", out_valid);
    end
    step(1'b1, 1'b0, 3'd0, '0, '0, '0);
    n_check++;
    if (out_valid !== 1'b1 || out_sin !== 17'd1000 || out_cos !== 17'(-40000)) begin
      n_err++;
      $display("FAIL latency_edge3: valid=%b sin=%0d cos=%0d, expected 1 1000 -40000",
               out_valid, $signed(out_sin), $signed(out_cos));
    end
    flush();
  endtask

  task automatic test_axis();
    step(1'b1, 1'b1, 3'd0, 8'd0, 16'd0, 16'd65535);
    step(1'b1, 1'b1, 3'd4, 8'd0, 16'd0, 16'd65535);
    step(1'b1, 1'b0, 3'd0, '0, '0, '0);
    n_check++;
    if (out_valid !== 1'b1 || out_sin !== 17'd0 || out_cos !== 17'd65535) begin
      n_err++;
      $display("FAIL axis_oct0: valid=%b sin=%0d cos=%0d, expected 1 0 65535",
               out_valid, $signed(out_sin), $signed(out_cos));
    end
    step(1'b1, 1'b0, 3'd0, '0, '0, '0);
    n_check++;
    if (out_valid !== 1'b1 || out_sin !== 17'd0 || out_cos !== 17'(-65535)) begin
      n_err++;
      $display("FAIL axis_oct4: valid=%b sin=%0d cos=%0d, expected 1 0 -65535",
               out_valid, $signed(out_sin), $signed(out_cos));
    end
    flush();
  endtask

  task automatic test_fine_and_saturation();
    step(1'b1, 1'b1, 3'd0, 8'd128, 16'd1000, 16'd40000);
    step(1'b1, 1'b1, 3'd0, 8'd255, 16'd65500, 16'd65535);
    step(1'b1, 1'b0, 3'd0, '0, '0, '0);
    n_check++;
    if (out_valid !== 1'b1 || out_sin !== 17'd1245 || out_cos !== 17'd39994) begin
      n_err++;
      $display("FAIL fine_corr: valid=%b sin=%0d cos=%0d, expected 1 1245 39994",
               out_valid, $signed(out_sin), $signed(out_cos));
    end
    step(1'b1, 1'b0, 3'd0, '0, '0, '0);
    n_check++;
    if (out_valid !== 1'b1 || out_sin !== 17'd65535 || out_cos !== 17'd64735) begin
      n_err++;
      $display("FAIL saturation: valid=%b sin=%0d cos=%0d, expected 1 65535 64735",
               out_valid, $signed(out_sin), $signed(out_cos));
    end
    flush();
  endtask

  task automatic test_all_octants();
    int         exp_s [8] = '{1000, 40000, 40000, 1000, -1000, -40000, -40000, -1000};
    int         exp_c [8] = '{40000, 1000, -1000, -40000, -40000, -1000, 1000, 40000};
    logic [W:0] ts, tc;
    for (int i = 0; i <= 10; i++) begin
      step(1'b1, i < 8, 3'(i), 8'd0, 16'd1000, 16'd40000);
      if (i >= 2 && i <= 9) begin
        ts = 17'(exp_s[i-2]);
        tc = 17'(exp_c[i-2]);
        n_check++;
        if (out_valid !== 1'b1 || out_sin !== ts || out_cos !== tc) begin
          n_err++;
          $display("FAIL octant_%0d: valid=%b sin=%0d cos=%0d, expected 1 %0d %0d",
                   i - 2, out_valid, $signed(out_sin), $signed(out_cos), exp_s[i-2], exp_c[i-2]);
        end
      end else if (i == 10) begin
        n_check++;
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL octant_tail: valid=%b, expected 0", out_valid);
        end
      end
    end
    flush();
  endtask

  // Stream 5 samples with a 4-cycle enable drop while samples are in flight.
  task automatic test_stall();
    exp_t       x;
    logic       pv;
    logic [W:0] ps, pc;
    bit         e;
    pv = out_valid; ps = out_sin; pc = out_cos;
    for (int i = 0; i < 14; i++) begin
      e = !(i >= 3 && i <= 6);
      step(e, i < 9, 3'($urandom_range(0, 7)), 8'($urandom), 16'($urandom), 16'($urandom));
      if (!e) begin
        n_check++;
        if (out_valid !== pv || out_sin !== ps || out_cos !== pc) begin
          n_err++;
          $display("FAIL stall_hold: valid=%b sin=%h cos=%h, expected %b %h %h",
                   out_valid, out_sin, out_cos, pv, ps, pc);
        end
      end else if (out_valid === 1'b1) begin
        n_check++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL stall_extra: valid=1 with no sample pending, expected 0");
        end else begin
          x = exp_q.pop_front();
          if (out_sin !== x.s || out_cos !== x.c || ecnt != x.idx + 2) begin
            n_err++;
            $display("FAIL stall_data: sin=%h cos=%h edge=%0d, expected %h %h %0d",
                     out_sin, out_cos, ecnt, x.s, x.c, x.idx + 2);
          end
        end
      end
      pv = out_valid; ps = out_sin; pc = out_cos;
    end
    n_check++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stall_lost: %0d samples left, expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  // Random traffic with random enable and bubbles, scored against the model.
  task automatic test_random();
    exp_t       x;
    logic       pv;
    logic [W:0] ps, pc;
    bit         e;
    pv = out_valid; ps = out_sin; pc = out_cos;
    for (int i = 0; i < 400; i++) begin
      e = (i >= 394) || ($urandom_range(0, 3) != 0);
      step(e, (i < 390) && ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)),
           8'($urandom), 16'($urandom), 16'($urandom));
      if (!e) begin
        n_check++;
        if (out_valid !== pv || out_sin !== ps || out_cos !== pc) begin
          n_err++;
          $display("FAIL rand_hold: valid=%b sin=%h cos=%h, expected %b %h %h",
                   out_valid, out_sin, out_cos, pv, ps, pc);
        end
      end else if (out_valid === 1'b1) begin
        n_check++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rand_extra: valid=1 with no sample pending, expected 0");
        end else begin
          x = exp_q.pop_front();
          if (out_sin !== x.s || out_cos !== x.c || ecnt != x.idx + 2) begin
            n_err++;
            $display("FAIL rand_data: sin=%h cos=%h edge=%0d, expected %h %h %0d",
                     out_sin, out_cos, ecnt, x.s, x.c, x.idx + 2);
          end
        end
      end else if (exp_q.size() != 0 && ecnt >= exp_q[0].idx + 2) begin
        n_check++;
        n_err++;
        $display("FAIL rand_missing: valid=%b at edge %0d, expected 1", out_valid, ecnt);
        void'(exp_q.pop_front());
      end
      pv = out_valid; ps = out_sin; pc = out_cos;
    end
    n_check++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rand_lost: %0d samples left, expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_axis();
    test_fine_and_saturation();
    test_all_octants();
    test_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_check);
    $finish;
  end

endmodule
`default_nettype wire
